// File: rtl/cube_plane_scheduler.sv
// cube_plane_scheduler: sequences loader restarts, ROM addressing and plane dwell for the LED cube
module cube_plane_scheduler #(
  parameter int unsigned NUM_PLANES   = 7,
  parameter int unsigned NUM_COLORS   = 3,
  parameter int unsigned NUM_FRAMES   = 7,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned FRAME_REPEAT = 50,
  parameter int unsigned LOAD_TIMEOUT = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  hold_frame,
  input  logic                  ld_finish,
  output logic                  ld_reset,
  output logic [15:0]           rom_addr,
  output logic [1:0]            color_sel,
  output logic [NUM_PLANES-1:0] plane_en,
  output logic                  blank,
  output logic                  frame_done,
  output logic                  load_err
);
  localparam int unsigned PW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
  localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned RW = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;
  localparam int unsigned CW = $clog2(((LOAD_TIMEOUT > DWELL_CYCLES) ? LOAD_TIMEOUT : DWELL_CYCLES) + 1);
  localparam logic [1:0]    C_LAST = 2'(NUM_COLORS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_PLANES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(FRAME_REPEAT - 1);
  localparam logic [FW-1:0] F_LAST = FW'(NUM_FRAMES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(LOAD_TIMEOUT - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [15:0]   FSTEP  = 16'(NUM_PLANES * NUM_COLORS);

  typedef enum logic [1:0] {IDLE, PREP, LOAD, SHOW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    color_q, color_d, color_sel_q, color_sel_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [15:0]   base_q, base_d, rom_addr_q, rom_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, done_q, done_d, adv;

  // Next state, slot/frame advance and the address latched on PREP entry
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    plane_d = plane_q;
    rep_d   = rep_q;
    frame_d = frame_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: state_d = run ? PREP : IDLE;
      PREP: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: begin
        if (ld_finish) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else if (cnt_q == T_LAST) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      SHOW: begin
        adv   = cnt_q == D_LAST;
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      state_d = run ? PREP : IDLE;
      color_d = (color_q == C_LAST) ? '0 : color_q + 2'd1;
      if (color_q == C_LAST) plane_d = (plane_q == P_LAST) ? '0 : plane_q + PW'(1);
      if (color_q == C_LAST && plane_q == P_LAST) rep_d = (rep_q == R_LAST) ? '0 : rep_q + RW'(1);
      if (color_q == C_LAST && plane_q == P_LAST && rep_q == R_LAST && !hold_frame) begin
        frame_d = (frame_q == F_LAST) ? '0 : frame_q + FW'(1);
        base_d  = (frame_q == F_LAST) ? '0 : base_q + FSTEP;
        done_d  = 1'b1;
      end
    end
    rom_addr_d  = (state_d == PREP) ? base_d + 16'(plane_d) * 16'(NUM_COLORS) + 16'(color_d) : rom_addr_q;
    color_sel_d = (state_d == PREP) ? color_d : color_sel_q;
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      color_q     <= '0;
      plane_q     <= '0;
      rep_q       <= '0;
      frame_q     <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rom_addr_q  <= '0;
      color_sel_q <= '0;
    end else begin
      state_q     <= state_d;
      color_q     <= color_d;
      plane_q     <= plane_d;
      rep_q       <= rep_d;
      frame_q     <= frame_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
      rom_addr_q  <= rom_addr_d;
      color_sel_q <= color_sel_d;
    end
  end

  assign ld_reset   = (state_q == IDLE) || (state_q == PREP);
  assign blank      = state_q != SHOW;
  assign plane_en   = (state_q == SHOW) ? NUM_PLANES'(1) << plane_q : '0;
  assign rom_addr   = rom_addr_q;
  assign color_sel  = color_sel_q;
  assign frame_done = done_q;
  assign load_err   = err_q;
endmodule

// File: tb/tb_cube_plane_scheduler.sv
// tb_cube_plane_scheduler: scoreboard bench for the plane/colour scan sequencer
module tb_cube_plane_scheduler;
  typedef struct packed {logic [15:0] a; logic [1:0] c; logic [1:0] p;} exp_t;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, hold_frame = 1'b0;
  logic ld_finish, ld_reset, blank, frame_done, load_err;
  logic [15:0] rom_addr;
  logic [1:0] color_sel, plane_en;
  int errors = 0, checks = 0, fd_cnt = 0, lcnt = 0, stall_addr = -1;
  bit stall_all = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  cube_plane_scheduler #(
    .NUM_PLANES(2), .NUM_COLORS(3), .NUM_FRAMES(2),
    .DWELL_CYCLES(4), .FRAME_REPEAT(2), .LOAD_TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .hold_frame(hold_frame), .ld_finish(ld_finish),
    .ld_reset(ld_reset), .rom_addr(rom_addr), .color_sel(color_sel), .plane_en(plane_en),
    .blank(blank), .frame_done(frame_done), .load_err(load_err)
  );

  // loader model: finishes in the 10th cycle after ld_reset falls unless stalled
  always @(posedge clk) lcnt <= ld_reset ? 0 : lcnt + 1;
  assign ld_finish = !ld_reset && lcnt == 9 && !stall_all && (int'(rom_addr) != stall_addr);

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  always @(negedge clk) begin
    checks++;
    if ((plane_en == 2'b00 && blank !== 1'b1) || plane_en === 2'b11 || $isunknown(plane_en)) begin
      errors++;
      $display("FAIL blank_onehot: blank=%b plane_en=%b, required blank=1 when plane_en=0 and plane_en one-hot", blank, plane_en);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t slot(int fi, int pi, int ci);
    return '{a: 16'(fi * 6 + pi * 3 + ci), c: 2'(ci), p: 2'(1 << pi)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; hold_frame = 1'b0; stall_all = 1'b0; stall_addr = -1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic next_show(output logic [15:0] a, output logic [1:0] c, output logic [1:0] p, output int len);
    int t = 0;
    len = 0;
    do begin @(negedge clk); t++; end while (blank !== 1'b0 && t < 200);
    a = rom_addr; c = color_sel; p = plane_en;
    while (blank === 1'b0 && t < 400) begin len++; @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ld_reset, blank, plane_en, rom_addr, color_sel, frame_done, load_err} !== {1'b1, 1'b1, 2'b00, 16'd0, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: ld_reset=%b blank=%b plane_en=%b rom_addr=%0d color_sel=%0d frame_done=%b load_err=%b, required 1 1 00 0 0 0 0",
               ld_reset, blank, plane_en, rom_addr, color_sel, frame_done, load_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ld_reset !== 1'b1 || blank !== 1'b1 || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL idle_hold: ld_reset=%b blank=%b rom_addr=%0d, required 1 1 0", ld_reset, blank, rom_addr);
    end
  endtask

  task automatic test_frames();
    logic [15:0] a; logic [1:0] c, p; int len; exp_t e;
    do_reset();
    for (int f = 0; f < 2; f++) for (int r = 0; r < 2; r++) for (int pl = 0; pl < 2; pl++) for (int co = 0; co < 3; co++) q.push_back(slot(f, pl, co));
    q.push_back(slot(0, 0, 0));
    run = 1'b1;
    for (int i = 0; i < 25; i++) begin
      next_show(a, c, p, len);
      e = q.pop_front();
      checks++;
      if ({a, c, p} !== e || len != 4) begin
        errors++;
        $display("FAIL frames_show_%0d: addr=%0d color=%0d plane_en=%b len=%0d, required addr=%0d color=%0d plane_en=%b len=4", i, a, c, p, len, e.a, e.c, e.p);
      end
      if (i == 12 || i == 24) begin
        checks++;
        if (fd_cnt != (i == 12 ? 1 : 2)) begin
          errors++;
          $display("FAIL frame_done_count_%0d: got %0d, required %0d", i, fd_cnt, i == 12 ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] a; logic [1:0] c, p; int len, fd0; exp_t e;
    do_reset();
    fd0 = fd_cnt;
    hold_frame = 1'b1;
    for (int r = 0; r < 2; r++) for (int pl = 0; pl < 2; pl++) for (int co = 0; co < 3; co++) q.push_back(slot(0, pl, co));
    q.push_back(slot(0, 0, 0));
    run = 1'b1;
    for (int i = 0; i < 13; i++) begin
      next_show(a, c, p, len);
      e = q.pop_front();
      checks++;
      if ({a, c, p} !== e || len != 4) begin
        errors++;
        $display("FAIL hold_show_%0d: addr=%0d color=%0d plane_en=%b len=%0d, required addr=%0d color=%0d plane_en=%b len=4", i, a, c, p, len, e.a, e.c, e.p);
      end
    end
    checks++;
    if (fd_cnt != fd0) begin
      errors++;
      $display("FAIL hold_no_frame_done: got %0d pulses, required 0", fd_cnt - fd0);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] a; logic [1:0] c, p; int len, n, t; exp_t e;
    do_reset();
    stall_addr = 2;
    q.push_back(slot(0, 0, 0));
    q.push_back(slot(0, 0, 1));
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_show(a, c, p, len);
      e = q.pop_front();
      checks++;
      if ({a, c, p} !== e || len != 4) begin
        errors++;
        $display("FAIL timeout_show_%0d: addr=%0d color=%0d plane_en=%b len=%0d, required addr=%0d color=%0d plane_en=%b len=4", i, a, c, p, len, e.a, e.c, e.p);
      end
    end
    checks++;
    if (load_err !== 1'b0 || rom_addr !== 16'd2) begin
      errors++;
      $display("FAIL timeout_pre: load_err=%b rom_addr=%0d, required 0 2", load_err, rom_addr);
    end
    t = 0;
    while (ld_reset === 1'b1 && t < 50) begin @(negedge clk); t++; end
    n = 0;
    while (ld_reset === 1'b0 && blank === 1'b1 && t < 100) begin n++; @(negedge clk); t++; end
    checks++;
    if (n != 20 || load_err !== 1'b1 || rom_addr !== 16'd3 || ld_reset !== 1'b1) begin
      errors++;
      $display("FAIL timeout_expire: load_cycles=%0d load_err=%b rom_addr=%0d ld_reset=%b, required 20 1 3 1", n, load_err, rom_addr, ld_reset);
    end
    q.push_back(slot(0, 1, 0));
    next_show(a, c, p, len);
    e = q.pop_front();
    checks++;
    if ({a, c, p} !== e || len != 4 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next: addr=%0d color=%0d plane_en=%b len=%0d load_err=%b, required addr=%0d color=%0d plane_en=%b len=4 load_err=1", a, c, p, len, load_err, e.a, e.c, e.p);
    end
  endtask

  task automatic test_run_stop();
    logic [15:0] a; logic [1:0] c, p; int len, t; exp_t e;
    do_reset();
    q.push_back(slot(0, 0, 0));
    run = 1'b1;
    t = 0;
    while (blank !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    a = rom_addr; c = color_sel; p = plane_en;
    run = 1'b0;
    len = 0;
    while (blank === 1'b0 && t < 200) begin len++; @(negedge clk); t++; end
    e = q.pop_front();
    checks++;
    if ({a, c, p} !== e || len != 4) begin
      errors++;
      $display("FAIL stop_show: addr=%0d color=%0d plane_en=%b len=%0d, required addr=%0d color=%0d plane_en=%b len=4", a, c, p, len, e.a, e.c, e.p);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ld_reset !== 1'b1 || blank !== 1'b1 || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL stop_idle: ld_reset=%b blank=%b rom_addr=%0d, required 1 1 0", ld_reset, blank, rom_addr);
    end
    run = 1'b1;
    q.push_back(slot(0, 0, 1));
    @(negedge clk);
    checks++;
    if (rom_addr !== 16'd1 || color_sel !== 2'd1 || ld_reset !== 1'b1) begin
      errors++;
      $display("FAIL resume_prep: rom_addr=%0d color_sel=%0d ld_reset=%b, required 1 1 1", rom_addr, color_sel, ld_reset);
    end
    @(negedge clk);
    checks++;
    if (ld_reset !== 1'b0 || blank !== 1'b1) begin
      errors++;
      $display("FAIL resume_load: ld_reset=%b blank=%b, required 0 1", ld_reset, blank);
    end
    next_show(a, c, p, len);
    e = q.pop_front();
    checks++;
    if ({a, c, p} !== e || len != 4) begin
      errors++;
      $display("FAIL resume_show: addr=%0d color=%0d plane_en=%b len=%0d, required addr=%0d color=%0d plane_en=%b len=4", a, c, p, len, e.a, e.c, e.p);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] a; logic [1:0] c, p; int len, t; exp_t e;
    do_reset();
    stall_all = 1'b1;
    run = 1'b1;
    t = 0;
    while (load_err !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    checks++;
    if (load_err !== 1'b1 || ld_reset !== 1'b1 || rom_addr !== 16'd1) begin
      errors++;
      $display("FAIL mid_setup: load_err=%b ld_reset=%b rom_addr=%0d, required 1 1 1", load_err, ld_reset, rom_addr);
    end
    while (ld_reset !== 1'b0 && t < 80) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    reset = 1'b1; run = 1'b0;
    @(negedge clk);
    checks++;
    if ({ld_reset, blank, plane_en, rom_addr, color_sel, frame_done, load_err} !== {1'b1, 1'b1, 2'b00, 16'd0, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_load_reset: ld_reset=%b blank=%b plane_en=%b rom_addr=%0d color_sel=%0d frame_done=%b load_err=%b, required 1 1 00 0 0 0 0",
               ld_reset, blank, plane_en, rom_addr, color_sel, frame_done, load_err);
    end
    reset = 1'b0; stall_all = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ld_reset !== 1'b1 || blank !== 1'b1) begin
      errors++;
      $display("FAIL mid_load_idle: ld_reset=%b blank=%b, required 1 1", ld_reset, blank);
    end
    run = 1'b1;
    q.push_back(slot(0, 0, 0));
    next_show(a, c, p, len);
    e = q.pop_front();
    checks++;
    if ({a, c, p} !== e || len != 4) begin
      errors++;
      $display("FAIL mid_load_restart: addr=%0d color=%0d plane_en=%b len=%0d, required addr=%0d color=%0d plane_en=%b len=4", a, c, p, len, e.a, e.c, e.p);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_hold();
    test_timeout();
    test_run_stop();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
